// File: rtl/video_timing_pkg.sv
// Shared video timing constants for the raster generator and every consumer
// of hcount/vcount (game, sprite and overlay logic), so all agree on bounds.
package video_timing_pkg;

  // Default 1024x768 @ 60 Hz timing, in pixel clocks / lines.
  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;
  localparam int unsigned DEF_FPS      = 60;

  // Port widths of the counters; the totals must fit inside them.
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned FRAME_W  = 6;

  localparam int unsigned H_TOTAL_MAX = 1 << HCOUNT_W;
  localparam int unsigned V_TOTAL_MAX = 1 << VCOUNT_W;
  localparam int unsigned FPS_MAX     = 1 << FRAME_W;

  // Full period of one axis: visible region plus both porches and sync.
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Per-pixel flags that are registered alongside the counters.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active_draw;
    logic new_frame;
  } raster_flags_t;

endpackage

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel/line counters with registered sync,
// visible-region and frame-start flags, all aligned to the same pixel.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned FPS      = DEF_FPS
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                active_draw_out,
  output logic                new_frame_out,
  output logic [FRAME_W-1:0]  frame_count_out
);

  localparam int unsigned H_PERIOD = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_PERIOD = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_PERIOD - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_PERIOD - 1);
  localparam logic [FRAME_W-1:0]  F_LAST = FRAME_W'(FPS - 1);

  // Elaboration guards: totals must fit the counter ports.
  if (H_PERIOD > H_TOTAL_MAX) begin : g_h_total_check
    $error("video_sig_gen: H_TOTAL %0d exceeds %0d", H_PERIOD, H_TOTAL_MAX);
  end
  if (V_PERIOD > V_TOTAL_MAX) begin : g_v_total_check
    $error("video_sig_gen: V_TOTAL %0d exceeds %0d", V_PERIOD, V_TOTAL_MAX);
  end
  if (FPS > FPS_MAX || FPS == 0) begin : g_fps_check
    $error("video_sig_gen: FPS %0d outside 1..%0d", FPS, FPS_MAX);
  end
  if (V_ACTIVE == 0) begin : g_v_active_check
    $error("video_sig_gen: V_ACTIVE must be non-zero");
  end

  logic                h_wrap;
  logic [HCOUNT_W-1:0] h_next;
  logic [VCOUNT_W-1:0] v_next;
  raster_flags_t       flags_next;
  logic [FRAME_W-1:0]  frame_next;

  // Next raster position; vertical advances only on the horizontal wrap.
  always_comb begin
    h_wrap = (hcount_out == H_LAST);
    h_next = h_wrap ? '0 : hcount_out + HCOUNT_W'(1);
    v_next = vcount_out;
    if (h_wrap) begin
      v_next = (vcount_out == V_LAST) ? '0 : vcount_out + VCOUNT_W'(1);
    end
  end

  // Flags are decoded from the next position so that once registered they
  // describe the same pixel as the counters, giving zero relative skew.
  always_comb begin
    flags_next.hsync = !((32'(h_next) >= H_SYNC_START) && (32'(h_next) < H_SYNC_END));
    flags_next.vsync = !((32'(v_next) >= V_SYNC_START) && (32'(v_next) < V_SYNC_END));
    flags_next.active_draw = (32'(h_next) < H_ACTIVE) && (32'(v_next) < V_ACTIVE);
    flags_next.new_frame = (32'(h_next) == H_ACTIVE) && (32'(v_next) == V_ACTIVE - 1);
  end

  // Frame counter advances together with the new-frame pulse.
  always_comb begin
    frame_next = frame_count_out;
    if (flags_next.new_frame) begin
      frame_next = (frame_count_out == F_LAST) ? '0 : frame_count_out + FRAME_W'(1);
    end
  end

  // Horizontal pixel counter.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      hcount_out <= '0;
    end else begin
      hcount_out <= h_next;
    end
  end

  // Vertical line counter.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      vcount_out <= '0;
    end else begin
      vcount_out <= v_next;
    end
  end

  // Registered sync/visibility/frame-start flags; syncs idle high in reset.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      hsync_out       <= 1'b1;
      vsync_out       <= 1'b1;
      active_draw_out <= 1'b0;
      new_frame_out   <= 1'b0;
    end else begin
      hsync_out       <= flags_next.hsync;
      vsync_out       <= flags_next.vsync;
      active_draw_out <= flags_next.active_draw;
      new_frame_out   <= flags_next.new_frame;
    end
  end

  // Frame counter register, wrapping at FPS.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      frame_count_out <= '0;
    end else begin
      frame_count_out <= frame_next;
    end
  end

endmodule
